// File: rtl/rvv_seq_pkg.sv
// -----------------------------------------------------------------------------
// rvv_seq_pkg
// Shared types for the VRF request sequencer slice.
//   ele_cnt_t   : element count within one VRF word (0..MASK_WIDTH)
//   vl_t        : vector length / vstart (0..MAX_VL)
//   vrf_addr_t  : VRF word address
//   seq_state_e : sequencer FSM states
// -----------------------------------------------------------------------------
package rvv_seq_pkg;

  localparam int unsigned MASK_WIDTH = 8;
  localparam int unsigned MAX_VL     = 256;
  localparam int unsigned ADDR_WIDTH = 8;

  typedef logic [$clog2(MASK_WIDTH):0] ele_cnt_t;
  typedef logic [$clog2(MAX_VL):0]     vl_t;
  typedef logic [ADDR_WIDTH-1:0]       vrf_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mask_generator_v1.sv
// -----------------------------------------------------------------------------
// mask_generator_v1
// Builds the per-element write strobe of one VRF word from the beat flags.
// Ports:
//   first_i, last_i         : beat is the first / last of its operation
//   skip_first_i            : leading inactive elements (used when first_i)
//   skip_last_i             : trailing inactive elements (used when last_i)
//   mask_o [MaskWidth-1:0]  : bit i set when element i is active
// -----------------------------------------------------------------------------
module mask_generator_v1 #(
  parameter int unsigned MaskWidth = 8
) (
  input  logic                         first_i,
  input  logic                         last_i,
  input  logic [$clog2(MaskWidth):0]   skip_first_i,
  input  logic [$clog2(MaskWidth):0]   skip_last_i,
  output logic [MaskWidth-1:0]         mask_o
);

  localparam int unsigned EleW = $clog2(MaskWidth) + 1;

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < MaskWidth; i++) begin
      // Element i is active unless it is in the skipped head or the skipped tail.
      mask_o[i] = (!first_i || (EleW'(i) >= skip_first_i)) &&
                  (!last_i  || (EleW'(i) <  (EleW'(MaskWidth) - skip_last_i)));
    end
  end

endmodule

// File: rtl/vrf_req_sequencer.sv
// -----------------------------------------------------------------------------
// vrf_req_sequencer
// Splits one vector operation's element range [vstart, vl) into per-VRF-word
// beats for the downstream write-mask generator.
//
// Optional build macro: RVV_SEQ_MASK_EN adds beat_mask_o, driven by an
// internal mask_generator_v1 instance.
//
// Ports:
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   op_valid_i / op_ready_o       : operation handshake
//   op_vstart_i, op_vl_i          : element range (vl clamped to MaxVl)
//   op_base_addr_i                : VRF word address of element 0
//   beat_valid_o / beat_ready_i   : beat handshake
//   beat_addr_o                   : VRF word address of the beat
//   beat_first_o, beat_last_o     : beat position flags
//   beat_skip_first_o/_last_o     : head / tail skip counts
//   beat_mask_o                   : per-element strobe (RVV_SEQ_MASK_EN only)
//   op_done_o                     : one-cycle pulse once the op has issued
//   dbg_state_o                   : current FSM state (0 IDLE, 1 ISSUE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds valid and all data stable until that edge; ready
// may change freely. op_ready_o is high only in IDLE.
// -----------------------------------------------------------------------------
module vrf_req_sequencer
  import rvv_seq_pkg::*;
#(
  parameter int unsigned MaskWidth = 8,
  parameter int unsigned MaxVl     = 256,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          op_valid_i,
  output logic                          op_ready_o,
  input  logic [$clog2(MaxVl):0]        op_vstart_i,
  input  logic [$clog2(MaxVl):0]        op_vl_i,
  input  logic [AddrWidth-1:0]          op_base_addr_i,
  output logic                          beat_valid_o,
  input  logic                          beat_ready_i,
  output logic [AddrWidth-1:0]          beat_addr_o,
  output logic                          beat_first_o,
  output logic                          beat_last_o,
  output logic [$clog2(MaskWidth):0]    beat_skip_first_o,
  output logic [$clog2(MaskWidth):0]    beat_skip_last_o,
`ifdef RVV_SEQ_MASK_EN
  output logic [MaskWidth-1:0]          beat_mask_o,
`endif
  output logic                          op_done_o,
  output logic                          dbg_state_o
);

  localparam int unsigned LogMw = $clog2(MaskWidth);
  localparam int unsigned EleW  = LogMw + 1;
  localparam int unsigned VlW   = $clog2(MaxVl) + 1;
  localparam int unsigned WordW = (MaxVl / MaskWidth > 1) ? $clog2(MaxVl / MaskWidth) : 1;

  seq_state_e           state_q, state_d;
  logic [WordW-1:0]     start_word_q, start_word_d;
  logic [WordW-1:0]     end_word_q, end_word_d;
  logic [WordW-1:0]     cur_word_q, cur_word_d;
  logic [EleW-1:0]      skip_first_q, skip_first_d;
  logic [EleW-1:0]      skip_last_q, skip_last_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic                 done_q, done_d;

  // Operation decode, evaluated on the incoming operation every cycle.
  logic [VlW-1:0]   vl_clamped;
  logic [VlW-1:0]   vl_minus1;
  logic [LogMw-1:0] vl_rem;
  logic             op_empty;
  logic             is_first;
  logic             is_last;
  logic             beat_hs;

  always_comb begin
    vl_clamped = (op_vl_i > VlW'(MaxVl)) ? VlW'(MaxVl) : op_vl_i;
    vl_minus1  = vl_clamped - VlW'(1);
    vl_rem     = vl_clamped[LogMw-1:0];
    op_empty   = (vl_clamped == '0) || (op_vstart_i >= vl_clamped);
  end

  always_comb begin
    is_first = (cur_word_q == start_word_q);
    is_last  = (cur_word_q == end_word_q);
    beat_hs  = (state_q == ISSUE) && beat_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      start_word_q <= '0;
      end_word_q   <= '0;
      cur_word_q   <= '0;
      skip_first_q <= '0;
      skip_last_q  <= '0;
      base_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_word_q <= start_word_d;
      end_word_q   <= end_word_d;
      cur_word_q   <= cur_word_d;
      skip_first_q <= skip_first_d;
      skip_last_q  <= skip_last_d;
      base_q       <= base_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_word_d = start_word_q;
    end_word_d   = end_word_q;
    cur_word_d   = cur_word_q;
    skip_first_d = skip_first_q;
    skip_last_d  = skip_last_q;
    base_d       = base_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid_i) begin
          if (op_empty) begin
            // Nothing to issue: report completion straight away.
            done_d = 1'b1;
          end else begin
            state_d      = ISSUE;
            start_word_d = WordW'(op_vstart_i >> LogMw);
            end_word_d   = WordW'(vl_minus1 >> LogMw);
            cur_word_d   = WordW'(op_vstart_i >> LogMw);
            skip_first_d = EleW'(op_vstart_i[LogMw-1:0]);
            // A vl that ends exactly on a word boundary leaves no tail gap.
            skip_last_d  = (vl_rem == '0) ? '0 : (EleW'(MaskWidth) - EleW'(vl_rem));
            base_d       = op_base_addr_i;
          end
        end
      end
      ISSUE: begin
        if (beat_hs) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cur_word_d = cur_word_q + WordW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat fields read zero outside ISSUE so idle/reset values are all-zero.
  always_comb begin
    op_ready_o        = (state_q == IDLE);
    beat_valid_o      = (state_q == ISSUE);
    beat_addr_o       = '0;
    beat_first_o      = 1'b0;
    beat_last_o       = 1'b0;
    beat_skip_first_o = '0;
    beat_skip_last_o  = '0;
    if (state_q == ISSUE) begin
      beat_addr_o       = base_q + AddrWidth'(cur_word_q);
      beat_first_o      = is_first;
      beat_last_o       = is_last;
      beat_skip_first_o = is_first ? skip_first_q : '0;
      beat_skip_last_o  = is_last  ? skip_last_q  : '0;
    end
    op_done_o   = done_q;
    dbg_state_o = state_q;
  end

`ifdef RVV_SEQ_MASK_EN
  mask_generator_v1 #(
    .MaskWidth(MaskWidth)
  ) u_mask_gen (
    .first_i      (beat_first_o),
    .last_i       (beat_last_o),
    .skip_first_i (beat_skip_first_o),
    .skip_last_i  (beat_skip_last_o),
    .mask_o       (beat_mask_o)
  );
`endif

endmodule

// File: tb/tb_vrf_req_sequencer.sv
module tb_vrf_req_sequencer;

  localparam int MW = 8;
  localparam int MAXVL = 256;
  localparam int BW = 26; // {addr8, first, last, skip_first4, skip_last4, mask8}

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [8:0] op_vstart;
  logic [8:0] op_vl;
  logic [7:0] op_base;
  logic       beat_valid;
  logic       beat_ready;
  logic [7:0] beat_addr;
  logic       beat_first;
  logic       beat_last;
  logic [3:0] beat_sf;
  logic [3:0] beat_sl;
  logic       op_done;
  logic       dbg_state;
  logic [7:0] obs_mask;

`ifdef RVV_SEQ_MASK_EN
  logic [7:0] beat_mask;
  assign obs_mask = beat_mask;
  localparam bit MASK_EN = 1'b1;
`else
  assign obs_mask = 8'h00;
  localparam bit MASK_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  vrf_req_sequencer dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .op_valid_i        (op_valid),
    .op_ready_o        (op_ready),
    .op_vstart_i       (op_vstart),
    .op_vl_i           (op_vl),
    .op_base_addr_i    (op_base),
    .beat_valid_o      (beat_valid),
    .beat_ready_i      (beat_ready),
    .beat_addr_o       (beat_addr),
    .beat_first_o      (beat_first),
    .beat_last_o       (beat_last),
    .beat_skip_first_o (beat_sf),
    .beat_skip_last_o  (beat_sl),
`ifdef RVV_SEQ_MASK_EN
    .beat_mask_o       (beat_mask),
`endif
    .op_done_o         (op_done),
    .dbg_state_o       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk every active element, group by VRF word.
  task automatic model_op(input int vs, input int vl, input int base);
    int vlc, fw, lw;
    exp_q.delete();
    vlc = (vl > MAXVL) ? MAXVL : vl;
    if (vlc == 0 || vs >= vlc) return;
    fw = vs / MW;
    lw = (vlc - 1) / MW;
    for (int w = fw; w <= lw; w++) begin
      logic [7:0] m;
      logic [7:0] a;
      logic       f, l;
      logic [3:0] sf, sl;
      m = 8'h00;
      for (int i = 0; i < MW; i++) begin
        int e;
        e = w * MW + i;
        m[i] = (e >= vs) && (e < vlc);
      end
      f  = (w == fw);
      l  = (w == lw);
      sf = f ? 4'(vs - w * MW) : 4'd0;
      sl = l ? 4'(w * MW + MW - vlc) : 4'd0;
      a  = 8'((base + w) % 256);
      exp_q.push_back({a, f, l, sf, sl, MASK_EN ? m : 8'h00});
    end
  endtask

  function automatic logic [BW-1:0] obs_beat();
    return {beat_addr, beat_first, beat_last, beat_sf, beat_sl, obs_mask};
  endfunction

  task automatic offer_op(input int vs, input int vl, input int base, input bit rnd);
    @(negedge clk);
    chk("op_ready_before_accept", op_ready, 1);
    op_valid   = 1'b1;
    op_vstart  = 9'(vs);
    op_vl      = 9'(vl);
    op_base    = 8'(base);
    beat_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
    op_vstart = 9'($urandom_range(0, 511));
    op_vl     = 9'($urandom_range(0, 511));
  endtask

  // Drives one operation and checks every beat and the completion pulse.
  task automatic run_op(input string name, input int vs, input int vl, input int base, input bit rnd);
    int cycles;
    int nbeats;
    int last_addr;
    model_op(vs, vl, base);
    offer_op(vs, vl, base, rnd);
    if (exp_q.size() == 0) begin
      @(negedge clk);
      chk({name, "_empty_done"}, op_done, 1);
      chk({name, "_empty_valid"}, beat_valid, 0);
      chk({name, "_empty_ready"}, op_ready, 1);
      @(negedge clk);
      chk({name, "_empty_done_once"}, op_done, 0);
      chk({name, "_empty_valid2"}, beat_valid, 0);
      return;
    end
    cycles = 0;
    nbeats = 0;
    last_addr = -1;
    while (exp_q.size() > 0 && cycles < 400) begin
      bit hs;
      @(negedge clk);
      cycles++;
      chk({name, "_valid"}, beat_valid, 1);
      chk({name, "_ready_busy"}, op_ready, 0);
      chk({name, "_no_done"}, op_done, 0);
      chk({name, "_beat"}, obs_beat(), exp_q[0]);
      hs = beat_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        void'(exp_q.pop_front());
        nbeats++;
      end
      beat_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk({name, "_budget_left"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_done"}, op_done, 1);
    chk({name, "_valid_after"}, beat_valid, 0);
    chk({name, "_ready_after"}, op_ready, 1);
    @(negedge clk);
    chk({name, "_done_once"}, op_done, 0);
    beat_ready = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    op_vstart  = '0;
    op_vl      = '0;
    op_base    = '0;
    beat_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_ready", op_ready, 1);
    chk("rst_valid", beat_valid, 0);
    chk("rst_done", op_done, 0);
    chk("rst_beat", obs_beat(), 0);

    // directed cases
    run_op("multi", 3, 20, 'h10, 1'b0);
    run_op("single", 2, 5, 'h40, 1'b0);
    run_op("aligned", 0, 16, 'h20, 1'b0);
    run_op("empty_vl0", 0, 0, 'h00, 1'b0);
    run_op("empty_eq", 9, 9, 'h00, 1'b0);
    run_op("bp64", 0, 64, 'h30, 1'b1);
    run_op("wrap", 0, 32, 'hFE, 1'b0);
    run_op("clamp", 250, 300, 'h05, 1'b0);
    run_op("clamp_full", 0, 511, 'h00, 1'b1);

    // back-to-back operations: next offer lands right after done
    run_op("b2b_a", 7, 9, 'h80, 1'b0);
    run_op("b2b_b", 8, 9, 'h80, 1'b0);

    // reset during the second beat of an 8-beat operation
    model_op(0, 64, 'h50);
    offer_op(0, 64, 'h50, 1'b0);
    @(negedge clk);
    chk("rstmid_beat0", obs_beat(), exp_q[0]);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstmid_beat1", obs_beat(), exp_q[1]);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", beat_valid, 0);
    chk("rstmid_ready", op_ready, 1);
    chk("rstmid_done", op_done, 0);
    @(negedge clk);
    chk("rstmid_done2", op_done, 0);
    chk("rstmid_valid2", beat_valid, 0);
    run_op("after_rst", 17, 40, 'hF0, 1'b1);

    // randomized operations
    for (int n = 0; n < 30; n++) begin
      int vs, vl;
      vl = $urandom_range(0, 300);
      vs = $urandom_range(0, (vl > 20) ? vl + 4 : 24);
      run_op("rand", vs, vl, $urandom_range(0, 255), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vrf_req_sequencer.md
Name: vrf_req_sequencer

Overview:
- Upstream neighbour of the VRF write-mask generator.
- Accepts one vector operation described by vstart, vl and base VRF word address.
- Splits the element range [vstart, vl) into per-VRF-word beats.
- Each beat carries the word address plus the first/last flags and the head/tail skip counts that the downstream mask generator consumes to build the per-word strobe.

Parameters:
- MaskWidth, 8, elements per VRF word; power of two, >= 2.
- MaxVl, 256, maximum vl in elements; multiple of MaskWidth.
- AddrWidth, 8, VRF word address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- op_valid_i  in  1  operation offered.
- op_ready_o  out  1  sequencer idle, can accept an operation.
- op_vstart_i  in  $clog2(MaxVl)+1  first active element.
- op_vl_i  in  $clog2(MaxVl)+1  element count bound (exclusive end).
- op_base_addr_i  in  AddrWidth  VRF word address of element 0.
- beat_valid_o  out  1  beat available.
- beat_ready_i  in  1  downstream accepts beat.
- beat_addr_o  out  AddrWidth  VRF word address of the beat.
- beat_first_o  out  1  first beat of the operation.
- beat_last_o  out  1  last beat of the operation.
- beat_skip_first_o  out  $clog2(MaskWidth)+1  leading inactive elements (valid only when first).
- beat_skip_last_o  out  $clog2(MaskWidth)+1  trailing inactive elements (valid only when last).
- op_done_o  out  1  one-cycle pulse when the operation has fully issued.

Behaviour:
- Reset: one clock, synchronous, active-low (rst_ni sampled on clk_i rising edge). Reset values: state IDLE, op_ready_o=1, beat_valid_o=0, op_done_o=0; all beat_* data fields 0.
- States are IDLE and ISSUE.
- IDLE: op_ready_o=1. On op_valid_i & op_ready_o, register the operation and compute:
  - start_word = vstart / MaskWidth; end_word = (vl-1) / MaskWidth.
  - skip_first = vstart % MaskWidth.
  - skip_last = (MaskWidth - vl % MaskWidth) % MaskWidth.
- Empty operation (vl==0 or vstart>=vl): no beat is ever emitted. Stay IDLE; op_done_o pulses in the cycle after acceptance.
- Non-empty operation: next state ISSUE; cur_word=start_word.
- ISSUE: beat_valid_o=1, op_ready_o=0.
  - beat_addr_o = base_addr + cur_word, truncated to AddrWidth, wraps modulo 2^AddrWidth.
  - beat_first_o = (cur_word==start_word).
  - beat_last_o = (cur_word==end_word); first and last may both be 1.
  - beat_skip_first_o = first ? skip_first : 0.
  - beat_skip_last_o = last ? skip_last : 0.
- Beat data is held stable while beat_valid_o & !beat_ready_i; beat_valid_o never drops without a handshake.
- On handshake: a non-last beat increments cur_word. A last beat returns to IDLE and asserts op_done_o for exactly the next cycle.
- First beat appears the cycle after operation acceptance (latency 1). With beat_ready_i held at 1 the block issues one beat per cycle.
- No new operation is accepted in the cycle of the last beat; the next acceptance is at earliest the following cycle.
- Reset mid-operation aborts: no further beats, no op_done_o.
- Inputs beyond MaxVl (vl>MaxVl) are clamped to MaxVl before computation.

Optional Feature:
- RVV_SEQ_MASK_EN: when defined, adds output beat_mask_o [MaskWidth-1:0].
  - It is the per-element strobe for the current beat, computed combinationally from first/last/skip values.
  - Bit i=1 iff element i of the word lies in [vstart, vl).
  - It is produced by an internal instance of mask_generator_v1.
- When undefined, the port and the instance are absent; the downstream stage builds the mask itself.

Decomposition:
- Shared package rvv_seq_pkg holds:
  - ele_cnt_t (logic [$clog2(MaskWidth):0]);
  - vl_t (logic [$clog2(MaxVl):0]);
  - vrf_addr_t;
  - state enum seq_state_e {IDLE, ISSUE}.
- No mandatory sub-module. The only instance is mask_generator_v1, under RVV_SEQ_MASK_EN.

Test Plan:
- Multi-beat: vstart=3, vl=20, base=0x10 -> 3 beats, addr 0x10/0x11/0x12. Beat0: first=1, skip_first=3. Beat2: last=1, skip_last=4. op_done_o pulses once, the cycle after beat2. With mask enabled: masks 0xF8, 0xFF, 0x0F.
- Single beat: vstart=2, vl=5 -> 1 beat with first=last=1, skip_first=2, skip_last=3, mask 0x1C.
- Aligned: vstart=0, vl=16 -> 2 beats, skip_first=0, skip_last=0, masks 0xFF, 0xFF.
- Empty: vl=0, and separately vstart=9/vl=9 -> beat_valid_o stays 0; op_done_o pulses 1 cycle after acceptance; op_ready_o stays 1.
- Backpressure: beat_ready_i toggled randomly over vstart=0, vl=64 -> exactly 8 beats, addresses ascending, data stable while stalled, op_ready_o=0 until the last handshake.
- Reset mid-op: rst_ni low during beat 2 of 8 -> next cycle beat_valid_o=0, op_ready_o=1, no op_done_o; a subsequent op issues correctly from its own start_word.
